// File: rtl/issue_ctl.sv
// Issue-stage sequencer: gates the issue-queue head into the EUs and ROB,
// serialises fence/CSR heads and parks after excepting heads until flush.
`timescale 1ns/1ps
module issue_ctl #(
  parameter int NUM_EU = 6,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              iq_valid_i,
  output logic              iq_ready_o,
  input  logic [NUM_EU-1:0] eu_sel_i,
  input  logic              serialize_i,
  input  logic              except_raised_i,
  input  logic [NUM_EU-1:0] eu_ready_i,
  output logic [NUM_EU-1:0] eu_valid_o,
  input  logic              rob_ready_i,
  output logic              rob_valid_o,
  input  logic              rob_empty_i,
  input  logic              ser_commit_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [2:0]        state_o
);

  localparam logic [2:0] S_NORMAL      = 3'd0;
  localparam logic [2:0] S_WAIT_EMPTY  = 3'd1;
  localparam logic [2:0] S_WAIT_COMMIT = 3'd2;
  localparam logic [2:0] S_EXC_HOLD    = 3'd3;

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             eu_ok;
  logic             base_ok;
  logic             issue;

  assign eu_ok = (eu_sel_i == '0) |
                 (|(eu_sel_i & eu_ready_i));

  // Reset and flush both kill every strobe combinationally.
  assign base_ok = rst_ni & iq_valid_i &
                   rob_ready_i & ~flush_i;

  always_comb begin
    issue   = 1'b0;
    state_d = state_q;
    case (state_q)
      S_NORMAL: begin
        if (iq_valid_i & except_raised_i) begin
          issue = base_ok;
          if (issue) state_d = S_EXC_HOLD;
        end else if (iq_valid_i & serialize_i) begin
          state_d = S_WAIT_EMPTY;
        end else begin
          issue = base_ok & eu_ok;
        end
      end
      S_WAIT_EMPTY: begin
        issue = base_ok & eu_ok & rob_empty_i;
        if (issue) state_d = S_WAIT_COMMIT;
      end
      S_WAIT_COMMIT: begin
        if (ser_commit_i) state_d = S_NORMAL;
      end
      S_EXC_HOLD: begin
        state_d = S_EXC_HOLD;
      end
      default: state_d = S_NORMAL;
    endcase
    if (flush_i) state_d = S_NORMAL;
  end

  always_comb begin
    stall_d = stall_q;
    if (iq_valid_i & ~issue & ~flush_i & ~(&stall_q))
      stall_d = stall_q + CNT_ONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_NORMAL;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  assign iq_ready_o  = issue;
  assign rob_valid_o = issue;
  assign eu_valid_o  = {NUM_EU{issue & ~except_raised_i}} &
                       eu_sel_i;
  assign stall_cnt_o = stall_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_issue_ctl.sv
// Bench for issue_ctl: directed scenarios plus random traffic checked
// against a mode-flag reference model; a CNT_W=4 twin covers saturation.
`timescale 1ns/1ps
module tb_issue_ctl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       iq_valid = 1'b0;
  logic [5:0] sel = '0;
  logic       ser = 1'b0;
  logic       exc = 1'b0;
  logic [5:0] eu_rdy = '1;
  logic       rob_rdy = 1'b1;
  logic       rob_empty = 1'b1;
  logic       ser_commit = 1'b0;

  logic        iq_ready, rob_valid;
  logic [5:0]  eu_valid;
  logic [31:0] stall32;
  logic [2:0]  state;
  logic        iq_ready4, rob_valid4;
  logic [5:0]  eu_valid4;
  logic [3:0]  stall4;
  logic [2:0]  state4;

  int tn = 0;
  int nf = 0;

  always #5 clk = ~clk;

  issue_ctl #(.NUM_EU(6), .CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .iq_valid_i(iq_valid), .iq_ready_o(iq_ready),
    .eu_sel_i(sel), .serialize_i(ser),
    .except_raised_i(exc), .eu_ready_i(eu_rdy),
    .eu_valid_o(eu_valid), .rob_ready_i(rob_rdy),
    .rob_valid_o(rob_valid), .rob_empty_i(rob_empty),
    .ser_commit_i(ser_commit), .stall_cnt_o(stall32),
    .state_o(state)
  );

  issue_ctl #(.NUM_EU(6), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .iq_valid_i(iq_valid), .iq_ready_o(iq_ready4),
    .eu_sel_i(sel), .serialize_i(ser),
    .except_raised_i(exc), .eu_ready_i(eu_rdy),
    .eu_valid_o(eu_valid4), .rob_ready_i(rob_rdy),
    .rob_valid_o(rob_valid4), .rob_empty_i(rob_empty),
    .ser_commit_i(ser_commit), .stall_cnt_o(stall4),
    .state_o(state4)
  );

  // Reference model: which kind of wait the stage is in, as flags.
  bit     m_we = 0, m_wc = 0, m_hold = 0;
  longint m_c32 = 0;
  int     m_c4 = 0;

  function automatic bit m_issue();
    bit eu_ok;
    eu_ok = (sel == 6'd0) || ((sel & eu_rdy) != 6'd0);
    if (!rst_n || flush || !iq_valid || !rob_rdy) return 0;
    if (m_hold || m_wc) return 0;
    if (m_we) return rob_empty && eu_ok;
    if (exc) return 1;
    if (ser) return 0;
    return eu_ok;
  endfunction

  function automatic logic [2:0] m_state();
    if (m_hold) return 3'd3;
    if (m_wc) return 3'd2;
    if (m_we) return 3'd1;
    return 3'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_we <= 0; m_wc <= 0; m_hold <= 0;
      m_c32 <= 0; m_c4 <= 0;
    end else begin
      if (iq_valid && !m_issue() && !flush) begin
        if (m_c32 < 64'hFFFF_FFFF) m_c32 <= m_c32 + 1;
        if (m_c4 < 15) m_c4 <= m_c4 + 1;
      end
      if (flush) begin
        m_we <= 0; m_wc <= 0; m_hold <= 0;
      end else if (m_hold) begin
        m_hold <= 1;
      end else if (m_wc) begin
        if (ser_commit) m_wc <= 0;
      end else if (m_we) begin
        if (m_issue()) begin m_we <= 0; m_wc <= 1; end
      end else if (iq_valid && exc) begin
        if (m_issue()) m_hold <= 1;
      end else if (iq_valid && ser) begin
        m_we <= 1;
      end
    end
  end

  always @(negedge clk)
    if (rst_n && iq_valid && !$onehot0(sel))
      $error("illegal multi-hot eu_sel %b", sel);

  task automatic idle();
    flush = 0; iq_valid = 0; sel = '0; ser = 0; exc = 0;
    eu_rdy = '1; rob_rdy = 1; rob_empty = 1; ser_commit = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    iq_valid = 1; sel = 6'b000001;
    #3;
    tn++;
    if ({iq_ready, rob_valid, eu_valid} !== 8'd0) begin
      nf++;
      $display("FAIL reset_strobes got %b want 0",
               {iq_ready, rob_valid, eu_valid});
    end
    tn++;
    if (stall32 !== 32'd0 || state !== 3'd0) begin
      nf++;
      $display("FAIL reset_state got cnt=%0d st=%0d want 0/0",
               stall32, state);
    end
    nxt();
    rst_n = 1;
    idle();
    nxt();
  endtask

  task automatic test_back_to_back();
    iq_valid = 1; sel = 6'b000001;
    repeat (5) begin
      @(negedge clk);
      tn++;
      if (iq_ready !== 1'b1 || rob_valid !== 1'b1 ||
          eu_valid !== 6'b000001 || stall32 !== 32'd0) begin
        nf++;
        $display("FAIL b2b got rdy=%b rob=%b eu=%b cnt=%0d want 1/1/000001/0",
                 iq_ready, rob_valid, eu_valid, stall32);
      end
      nxt();
    end
    idle();
    nxt();
  endtask

  task automatic test_backpressure();
    iq_valid = 1; sel = 6'b000001; eu_rdy = 6'b111110;
    repeat (3) begin
      @(negedge clk);
      tn++;
      if ({iq_ready, rob_valid, eu_valid} !== 8'd0) begin
        nf++;
        $display("FAIL bp_blocked got %b want 0",
                 {iq_ready, rob_valid, eu_valid});
      end
      nxt();
    end
    eu_rdy = '1;
    @(negedge clk);
    tn++;
    if (stall32 !== 32'd3 || iq_ready !== 1'b1 ||
        eu_valid !== 6'b000001) begin
      nf++;
      $display("FAIL bp_release got cnt=%0d rdy=%b eu=%b want 3/1/000001",
               stall32, iq_ready, eu_valid);
    end
    nxt();
    idle();
    nxt();
  endtask

  task automatic test_serialize();
    iq_valid = 1; ser = 1; sel = 6'b000010; rob_empty = 0;
    @(negedge clk);
    tn++;
    if (iq_ready !== 1'b0 || state !== 3'd0) begin
      nf++;
      $display("FAIL ser_first got rdy=%b st=%0d want 0/0",
               iq_ready, state);
    end
    nxt();
    repeat (4) begin
      @(negedge clk);
      tn++;
      if (iq_ready !== 1'b0 || state !== 3'd1) begin
        nf++;
        $display("FAIL ser_wait got rdy=%b st=%0d want 0/1",
                 iq_ready, state);
      end
      nxt();
    end
    rob_empty = 1;
    @(negedge clk);
    tn++;
    if (iq_ready !== 1'b1 || rob_valid !== 1'b1 ||
        eu_valid !== 6'b000010) begin
      nf++;
      $display("FAIL ser_issue got rdy=%b rob=%b eu=%b want 1/1/000010",
               iq_ready, rob_valid, eu_valid);
    end
    nxt();
    ser = 0; sel = 6'b000001; rob_empty = 0;
    @(negedge clk);
    tn++;
    if (iq_ready !== 1'b0 || state !== 3'd2) begin
      nf++;
      $display("FAIL ser_commit_wait got rdy=%b st=%0d want 0/2",
               iq_ready, state);
    end
    nxt();
    ser_commit = 1;
    @(negedge clk);
    tn++;
    if (iq_ready !== 1'b0 || state !== 3'd2) begin
      nf++;
      $display("FAIL ser_pulse_cycle got rdy=%b st=%0d want 0/2",
               iq_ready, state);
    end
    nxt();
    ser_commit = 0;
    @(negedge clk);
    tn++;
    if (iq_ready !== 1'b1 || state !== 3'd0) begin
      nf++;
      $display("FAIL ser_after_pulse got rdy=%b st=%0d want 1/0",
               iq_ready, state);
    end
    tn++;
    if (stall32 !== m_c32[31:0]) begin
      nf++;
      $display("FAIL ser_cnt got %0d want %0d", stall32, m_c32);
    end
    nxt();
    idle();
    nxt();
  endtask

  task automatic test_exception();
    iq_valid = 1; exc = 1; sel = 6'b000100; eu_rdy = '0;
    @(negedge clk);
    tn++;
    if (rob_valid !== 1'b1 || iq_ready !== 1'b1 ||
        eu_valid !== 6'd0) begin
      nf++;
      $display("FAIL exc_issue got rob=%b rdy=%b eu=%b want 1/1/0",
               rob_valid, iq_ready, eu_valid);
    end
    nxt();
    exc = 0; sel = 6'b000001; eu_rdy = '1;
    repeat (3) begin
      @(negedge clk);
      tn++;
      if (iq_ready !== 1'b0 || state !== 3'd3) begin
        nf++;
        $display("FAIL exc_hold got rdy=%b st=%0d want 0/3",
                 iq_ready, state);
      end
      nxt();
    end
    flush = 1;
    @(negedge clk);
    tn++;
    if ({iq_ready, rob_valid, eu_valid} !== 8'd0) begin
      nf++;
      $display("FAIL exc_flush got %b want 0",
               {iq_ready, rob_valid, eu_valid});
    end
    nxt();
    flush = 0;
    @(negedge clk);
    tn++;
    if (state !== 3'd0 || iq_ready !== 1'b1) begin
      nf++;
      $display("FAIL exc_resume got st=%0d rdy=%b want 0/1",
               state, iq_ready);
    end
    nxt();
    idle();
    nxt();
  endtask

  task automatic test_flush();
    iq_valid = 1; ser = 1; sel = 6'b001000; rob_empty = 0;
    nxt();
    rob_empty = 1; flush = 1;
    @(negedge clk);
    tn++;
    if ({iq_ready, rob_valid, eu_valid} !== 8'd0 ||
        state !== 3'd1) begin
      nf++;
      $display("FAIL flush_we got strobes=%b st=%0d want 0/1",
               {iq_ready, rob_valid, eu_valid}, state);
    end
    nxt();
    flush = 0; iq_valid = 0;
    @(negedge clk);
    tn++;
    if (state !== 3'd0) begin
      nf++;
      $display("FAIL flush_we_next got st=%0d want 0", state);
    end
    iq_valid = 1;
    nxt();
    nxt();
    ser = 0; sel = 6'b000001; flush = 1;
    @(negedge clk);
    tn++;
    if ({iq_ready, rob_valid, eu_valid} !== 8'd0 ||
        state !== 3'd2) begin
      nf++;
      $display("FAIL flush_wc got strobes=%b st=%0d want 0/2",
               {iq_ready, rob_valid, eu_valid}, state);
    end
    nxt();
    flush = 0;
    @(negedge clk);
    tn++;
    if (state !== 3'd0 || iq_ready !== 1'b1) begin
      nf++;
      $display("FAIL flush_wc_next got st=%0d rdy=%b want 0/1",
               state, iq_ready);
    end
    nxt();
    idle();
    nxt();
  endtask

  task automatic test_saturation();
    rst_n = 0; #2; rst_n = 1;
    iq_valid = 1; sel = 6'b000001; eu_rdy = '0;
    repeat (20) nxt();
    tn++;
    if (stall4 !== 4'd15 || stall32 !== 32'd20) begin
      nf++;
      $display("FAIL sat got c4=%0d c32=%0d want 15/20",
               stall4, stall32);
    end
    #2;
    eu_rdy = '1;
    rst_n = 0;
    #1;
    tn++;
    if (stall4 !== 4'd0 || stall32 !== 32'd0 ||
        state !== 3'd0 || iq_ready !== 1'b0 ||
        rob_valid !== 1'b0 || eu_valid !== 6'd0) begin
      nf++;
      $display("FAIL async_rst got c4=%0d c32=%0d st=%0d rdy=%b want 0/0/0/0",
               stall4, stall32, state, iq_ready);
    end
    nxt();
    rst_n = 1;
    idle();
    nxt();
  endtask

  task automatic test_random();
    int idx;
    for (int i = 0; i < 400; i++) begin
      iq_valid   = ($urandom_range(0, 3) != 0);
      idx        = $urandom_range(0, 6);
      sel        = '0;
      if (idx != 0) sel[idx-1] = 1'b1;
      eu_rdy     = 6'($urandom);
      rob_rdy    = ($urandom_range(0, 4) != 0);
      rob_empty  = $urandom_range(0, 1) == 1;
      ser        = ($urandom_range(0, 5) == 0);
      exc        = ($urandom_range(0, 7) == 0);
      ser_commit = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      tn++;
      if (iq_ready !== m_issue() || rob_valid !== m_issue() ||
          eu_valid !== ((m_issue() && !exc) ? sel : 6'd0) ||
          state !== m_state() || stall32 !== m_c32[31:0] ||
          stall4 !== 4'(m_c4) || iq_ready4 !== m_issue()) begin
        nf++;
        $display("FAIL rand[%0d] got rdy=%b eu=%b st=%0d c32=%0d c4=%0d want rdy=%b st=%0d c32=%0d c4=%0d",
                 i, iq_ready, eu_valid, state, stall32, stall4,
                 m_issue(), m_state(), m_c32, m_c4);
      end
      nxt();
    end
    idle();
    nxt();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_serialize();
    test_exception();
    test_flush();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tn, nf);
    $finish;
  end

endmodule
